// File: rtl/quadrature_decoder_if.sv
// Encoder pins, control strobes and position outputs of quadrature_decoder.
// The master side drives pins/controls; the slave side is the decoder.
interface quadrature_decoder_if #(
    parameter int COUNT_W = 36
);
    logic                      enc_a;
    logic                      enc_b;
    logic                      enc_i;
    logic                      enable;
    logic                      count_clear;
    logic                      err_clear;
    logic signed [COUNT_W-1:0] count;
    logic                      direction;
    logic                      step;
    logic                      error;

    modport master (
        output enc_a, enc_b, enc_i, enable, count_clear, err_clear,
        input  count, direction, step, error
    );

    modport slave (
        input  enc_a, enc_b, enc_i, enable, count_clear, err_clear,
        output count, direction, step, error
    );
endinterface

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder: 2-FF sync, stability filter, signed wrapping count, sticky error.
// Optional index reset of the count when QUAD_INDEX_RESET_EN is defined.

// Stability filter: a value is accepted after FILTER_LEN consecutive equal samples.
module quadrature_decoder_filt #(
    parameter int W           = 2,
    parameter int FILTER_LEN  = 4,
    parameter bit FORCE_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] prev_o,
    output logic         stb_o,
    output logic         first_o
);
    localparam logic [7:0] LEN = 8'(FILTER_LEN);

    logic [W-1:0] cand_q, acc_q, prev_q;
    logic [7:0]   run_q, run_d;
    logic         seen_q, stb_q, first_q;
    logic         take;

    // run_d counts the sample being taken this cycle; saturates at LEN.
    // Before the first acceptance a value equal to the reset state must still be taken.
    always_comb begin
        run_d = 8'd1;
        if (din_i == cand_q) run_d = (run_q == LEN) ? run_q : run_q + 8'd1;
        take = (run_d == LEN) && ((FORCE_FIRST && !seen_q) || (din_i != acc_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q  <= '0;
            acc_q   <= '0;
            prev_q  <= '0;
            run_q   <= '0;
            seen_q  <= 1'b0;
            stb_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            cand_q <= din_i;
            run_q  <= run_d;
            stb_q  <= take;
            if (take) begin
                acc_q   <= din_i;
                prev_q  <= acc_q;
                first_q <= !seen_q;
                seen_q  <= 1'b1;
            end
        end
    end

    assign acc_o   = acc_q;
    assign prev_o  = prev_q;
    assign stb_o   = stb_q;
    assign first_o = first_q;
endmodule

module quadrature_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int COUNT_W    = 36
) (
    input logic                 clk,
    input logic                 reset,
    quadrature_decoder_if.slave qd
);
    logic [1:0] ab_s1_q, ab_s2_q;
    logic [1:0] ab_acc, ab_prev;
    logic       ab_stb, ab_first;
    logic [1:0] delta;
    logic       valid, fwd, rev, bad;
    logic       idx_clr;

    logic signed [COUNT_W-1:0] count_q, count_d;
    logic                      dir_q, dir_d;
    logic                      step_q, step_d;
    logic                      err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ab_s1_q <= '0;
            ab_s2_q <= '0;
        end else begin
            ab_s1_q <= {qd.enc_a, qd.enc_b};
            ab_s2_q <= ab_s1_q;
        end
    end

    quadrature_decoder_filt #(
        .W(2), .FILTER_LEN(FILTER_LEN), .FORCE_FIRST(1'b1)
    ) u_ab_filt (
        .clk(clk), .rst(reset), .din_i(ab_s2_q),
        .acc_o(ab_acc), .prev_o(ab_prev), .stb_o(ab_stb), .first_o(ab_first)
    );

`ifdef QUAD_INDEX_RESET_EN
    logic idx_s1_q, idx_s2_q;
    logic idx_acc, idx_stb;
    logic idx_unused_prev, idx_unused_first;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_s1_q <= 1'b0;
            idx_s2_q <= 1'b0;
        end else begin
            idx_s1_q <= qd.enc_i;
            idx_s2_q <= idx_s1_q;
        end
    end

    quadrature_decoder_filt #(
        .W(1), .FILTER_LEN(FILTER_LEN), .FORCE_FIRST(1'b0)
    ) u_idx_filt (
        .clk(clk), .rst(reset), .din_i(idx_s2_q),
        .acc_o(idx_acc), .prev_o(idx_unused_prev), .stb_o(idx_stb),
        .first_o(idx_unused_first)
    );

    // An accepted change to 1 is a rising edge; it only counts while AB rests at 00.
    assign idx_clr = idx_stb && idx_acc && (ab_acc == 2'b00);
`else
    logic unused_enc_i;
    assign unused_enc_i = qd.enc_i;
    assign idx_clr      = 1'b0;
`endif

    // Gray phase along the forward sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase_f(input logic [1:0] ab);
        case (ab)
            2'b00:   phase_f = 2'd0;
            2'b10:   phase_f = 2'd1;
            2'b11:   phase_f = 2'd2;
            default: phase_f = 2'd3;
        endcase
    endfunction

    assign delta = phase_f(ab_acc) - phase_f(ab_prev);
    assign valid = ab_stb && !ab_first;
    assign fwd   = valid && (delta == 2'd1);
    assign rev   = valid && (delta == 2'd3);
    assign bad   = valid && (delta == 2'd2);

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
        if (qd.err_clear) err_d = 1'b0;
        if (bad)          err_d = 1'b1;
        if (qd.enable && (fwd || rev)) begin
            count_d = fwd ? count_q + COUNT_W'(1) : count_q - COUNT_W'(1);
            dir_d   = fwd;
            step_d  = 1'b1;
        end
        if (qd.count_clear || idx_clr) begin
            count_d = '0;
            step_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign qd.count     = count_q;
    assign qd.direction = dir_q;
    assign qd.step      = step_q;
    assign qd.error     = err_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: step table plus latency, glitch, error,
// wrap, clear, index, enable and reset-mid-filter sequences.
module tb_quadrature_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   nsteps = 0;
    int   snap;

    quadrature_decoder_if #(.COUNT_W(36)) qd ();

    quadrature_decoder #(.FILTER_LEN(4), .COUNT_W(36)) dut (
        .clk(clk), .reset(reset), .qd(qd.slave)
    );

    always #10 clk = ~clk;

    // Reads the value registered at the previous edge, so each pulse counts once.
    always @(posedge clk) if (qd.step) nsteps++;

    typedef struct {
        logic        a;
        logic        b;
        logic [35:0] cnt;
        logic        dir;
        int          steps;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic a, input logic b);
        qd.enc_a = a;
        qd.enc_b = b;
    endtask

    initial begin
        // forward 11,01,00,10,11,01,00 then twelve reverse steps down to -4
        tbl[0]  = '{1, 1, 36'd2, 1, 2};
        tbl[1]  = '{0, 1, 36'd3, 1, 3};
        tbl[2]  = '{0, 0, 36'd4, 1, 4};
        tbl[3]  = '{1, 0, 36'd5, 1, 5};
        tbl[4]  = '{1, 1, 36'd6, 1, 6};
        tbl[5]  = '{0, 1, 36'd7, 1, 7};
        tbl[6]  = '{0, 0, 36'd8, 1, 8};
        tbl[7]  = '{0, 1, 36'd7, 0, 9};
        tbl[8]  = '{1, 1, 36'd6, 0, 10};
        tbl[9]  = '{1, 0, 36'd5, 0, 11};
        tbl[10] = '{0, 0, 36'd4, 0, 12};
        tbl[11] = '{0, 1, 36'd3, 0, 13};
        tbl[12] = '{1, 1, 36'd2, 0, 14};
        tbl[13] = '{1, 0, 36'd1, 0, 15};
        tbl[14] = '{0, 0, 36'd0, 0, 16};
        tbl[15] = '{0, 1, 36'hF_FFFF_FFFF, 0, 17};
        tbl[16] = '{1, 1, 36'hF_FFFF_FFFE, 0, 18};
        tbl[17] = '{1, 0, 36'hF_FFFF_FFFD, 0, 19};
        tbl[18] = '{0, 0, 36'hF_FFFF_FFFC, 0, 20};

        set_ab(0, 0);
        qd.enc_i = 0;
        qd.enable = 1;
        qd.count_clear = 0;
        qd.err_clear = 0;
        cyc(5);
        chk("rst_count", qd.count, 36'd0);
        chk("rst_dir", 36'(qd.direction), 36'd0);
        chk("rst_step", 36'(qd.step), 36'd0);
        chk("rst_err", 36'(qd.error), 36'd0);
        reset = 0;
        cyc(20);
        chk("init_count", qd.count, 36'd0);
        chk("init_err", 36'(qd.error), 36'd0);
        chk("init_steps", 36'(nsteps), 36'd0);

        // first step: count must move on the 7th edge after the pin change
        set_ab(1, 0);
        cyc(6);
        chk("lat_e6_count", qd.count, 36'd0);
        chk("lat_e6_step", 36'(qd.step), 36'd0);
        cyc(1);
        chk("lat_e7_count", qd.count, 36'd1);
        chk("lat_e7_step", 36'(qd.step), 36'd1);
        chk("lat_e7_dir", 36'(qd.direction), 36'd1);
        cyc(1);
        chk("lat_e8_step", 36'(qd.step), 36'd0);
        cyc(18);

        for (int i = 0; i < 19; i++) begin
            set_ab(tbl[i].a, tbl[i].b);
            cyc(20);
            chk($sformatf("tbl%0d_count", i), qd.count, tbl[i].cnt);
            chk($sformatf("tbl%0d_dir", i), 36'(qd.direction), 36'(tbl[i].dir));
            chk($sformatf("tbl%0d_err", i), 36'(qd.error), 36'd0);
            chk($sformatf("tbl%0d_steps", i), 36'(nsteps), 36'(tbl[i].steps));
        end

        // glitches: 3 cycles rejected, 4 cycles accepted (and the return is a reverse step)
        qd.enc_a = 1;
        cyc(3);
        qd.enc_a = 0;
        cyc(20);
        chk("glitch3_count", qd.count, 36'hF_FFFF_FFFC);
        chk("glitch3_steps", 36'(nsteps), 36'd20);
        chk("glitch3_err", 36'(qd.error), 36'd0);
        qd.enc_a = 1;
        cyc(4);
        qd.enc_a = 0;
        cyc(3);
        chk("glitch4_count", qd.count, 36'hF_FFFF_FFFD);
        chk("glitch4_step", 36'(qd.step), 36'd1);
        cyc(20);
        chk("glitch4_back", qd.count, 36'hF_FFFF_FFFC);
        chk("glitch4_steps", 36'(nsteps), 36'd22);

        // illegal jump, clear, then clear colliding with a second illegal jump
        set_ab(1, 1);
        cyc(20);
        chk("ill_err", 36'(qd.error), 36'd1);
        chk("ill_count", qd.count, 36'hF_FFFF_FFFC);
        chk("ill_steps", 36'(nsteps), 36'd22);
        qd.err_clear = 1;
        cyc(1);
        qd.err_clear = 0;
        chk("errclr", 36'(qd.error), 36'd0);
        set_ab(0, 0);
        cyc(6);
        qd.err_clear = 1;
        cyc(1);
        qd.err_clear = 0;
        chk("errclr_vs_set", 36'(qd.error), 36'd1);
        cyc(20);
        chk("ill2_err", 36'(qd.error), 36'd1);
        chk("ill2_count", qd.count, 36'hF_FFFF_FFFC);
        qd.err_clear = 1;
        cyc(1);
        qd.err_clear = 0;

        // wrap at the positive limit, count_clear alone, then 0 - 1
        force dut.count_q = 36'h7_FFFF_FFFF;
        cyc(1);
        release dut.count_q;
        cyc(1);
        chk("preload", qd.count, 36'h7_FFFF_FFFF);
        set_ab(1, 0);
        cyc(20);
        chk("wrap_pos", qd.count, 36'h8_0000_0000);
        chk("wrap_dir", 36'(qd.direction), 36'd1);
        qd.count_clear = 1;
        cyc(1);
        qd.count_clear = 0;
        chk("cclr", qd.count, 36'd0);
        set_ab(0, 0);
        cyc(20);
        chk("wrap_neg", qd.count, 36'hF_FFFF_FFFF);
        chk("wrap_neg_dir", 36'(qd.direction), 36'd0);

        // count_clear on the same edge as a step
        set_ab(1, 0);
        cyc(6);
        qd.count_clear = 1;
        cyc(1);
        qd.count_clear = 0;
        chk("cclr_step_count", qd.count, 36'd0);
        chk("cclr_step_step", 36'(qd.step), 36'd0);
        cyc(20);
        chk("cclr_step_hold", qd.count, 36'd0);

        // index pulse at AB=00 and at AB=11
        set_ab(0, 0);
        cyc(20);
        force dut.count_q = 36'd37;
        cyc(1);
        release dut.count_q;
        cyc(1);
        qd.enc_i = 1;
        cyc(20);
        qd.enc_i = 0;
        cyc(20);
`ifdef QUAD_INDEX_RESET_EN
        chk("idx_ab00", qd.count, 36'd0);
`else
        chk("idx_ab00", qd.count, 36'd37);
`endif
        set_ab(1, 0);
        cyc(20);
        set_ab(1, 1);
        cyc(20);
        force dut.count_q = 36'd37;
        cyc(1);
        release dut.count_q;
        cyc(1);
        qd.enc_i = 1;
        cyc(20);
        qd.enc_i = 0;
        cyc(20);
        chk("idx_ab11", qd.count, 36'd37);

        // reset in the middle of a filter window; re-initialisation afterwards
        set_ab(0, 1);
        cyc(3);
        reset = 1;
        cyc(2);
        chk("mid_rst_count", qd.count, 36'd0);
        chk("mid_rst_dir", 36'(qd.direction), 36'd0);
        chk("mid_rst_step", 36'(qd.step), 36'd0);
        chk("mid_rst_err", 36'(qd.error), 36'd0);
        reset = 0;
        cyc(20);
        chk("reinit_count", qd.count, 36'd0);
        chk("reinit_err", 36'(qd.error), 36'd0);
        set_ab(0, 0);
        cyc(20);
        chk("reinit_step", qd.count, 36'd1);
        chk("reinit_dir", 36'(qd.direction), 36'd1);

        // enable low: state tracked, count frozen, no false error on re-enable
        snap = nsteps;
        qd.enable = 0;
        set_ab(1, 0);
        cyc(20);
        chk("en0_count", qd.count, 36'd1);
        chk("en0_steps", 36'(nsteps), 36'(snap));
        qd.enable = 1;
        set_ab(1, 1);
        cyc(20);
        chk("en1_count", qd.count, 36'd2);
        chk("en1_err", 36'(qd.error), 36'd0);
        chk("en1_steps", 36'(nsteps), 36'(snap + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Decodes the A/B (and optional index) signals of a motor's incremental encoder into a signed 36-bit position count.
- Sits between the encoder input pins and the 5 ms velocity-derivation stage, which samples `count` directly.
- Provides input synchronisation, a glitch filter, x4 decoding, direction and step outputs, and sticky illegal-transition detection.

Parameters:
- FILTER_LEN, 4: consecutive clk cycles a synchronised A/B value must be stable before it is accepted. Legal range 1..255.
- COUNT_W, 36: count width in bits. Must stay 36 for the velocity stage.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- enc_a  input  1  encoder channel A, asynchronous to clk
- enc_b  input  1  encoder channel B, asynchronous to clk
- enc_i  input  1  encoder index, asynchronous to clk
- enable  input  1  1 = count steps; 0 = hold count while still tracking A/B state
- count_clear  input  1  synchronous, one-cycle request: count <= 0
- err_clear  input  1  synchronous: clears error
- count  output  COUNT_W  signed position, two's complement
- direction  output  1  direction of the last valid step (1 = up)
- step  output  1  one-cycle pulse on each count change
- error  output  1  sticky illegal-transition flag

Behaviour:
- Reset (async, active-high): count=0, direction=0, step=0, error=0, filter counter=0, initialised flag=0. All synchroniser and filter registers are cleared.
- Synchronisation: 2-FF synchroniser on each of enc_a, enc_b and enc_i.
- Filter:
  - A candidate AB pair that differs from the accepted pair is loaded into the accepted state once it has been stable for FILTER_LEN consecutive cycles.
  - Any change restarts the stability counter.
  - Pulses shorter than FILTER_LEN cycles are never accepted.
- Initialisation:
  - The first accepted AB after reset loads the state only. No count change, no error.
  - Until then, step=0 and error cannot set.
- Decode sequence (A leads B = up): AB 00 -> 10 -> 11 -> 01 -> 00.
  - Adjacent forward transition: count +1, direction=1, step=1.
  - Adjacent reverse transition: count -1, direction=0, step=1.
  - Both bits changed: count unchanged, step=0, error<=1.
- Latency: an A/B edge at the pins produces the count update FILTER_LEN+3 clk edges later (default 7). step is asserted in the same cycle as the count update.
- Arithmetic: count wraps modulo 2^COUNT_W.
  - 0x7_FFFF_FFFF + 1 gives 0x8_0000_0000.
  - 0 - 1 gives 0xF_FFFF_FFFF.
  - No saturation.
- enable=0: the accepted state still updates, so no false error appears on re-enable. count, direction and step are frozen (step=0). Illegal jumps still set error.
- count_clear together with a valid step in the same cycle: clear wins, count=0, step=0.
- err_clear together with a new illegal transition: error stays 1 (set wins).
- Reset asserted mid-filter or mid-step: all state is discarded, and initialisation repeats after release.
- Outputs are registered. count is stable between steps, so a slower clock domain may sample it.

Optional Feature:
- Macro: QUAD_INDEX_RESET_EN.
- Defined:
  - A rising edge of the synchronised enc_i that coincides with accepted AB=00 clears count to 0 in the next cycle.
  - This takes priority over a step in that cycle; step is forced to 0.
  - enc_i is filtered with the same FILTER_LEN as A/B.
- Not defined: enc_i is ignored (the synchroniser may be optimised away) and count is affected only by steps, count_clear and reset.

Test Plan:
- Reset release, AB held 00, then 8 forward steps (00,10,11,01,... each held 20 cycles) -> count=8, direction=1, exactly 8 step pulses. Each pulse occurs 7 cycles after its edge.
- From count=8, 12 reverse steps -> count=-4 (0xF_FFFF_FFFC), direction=0.
- Glitch: A high for 3 cycles (FILTER_LEN=4) with AB=00 -> count, step and error unchanged. Repeat with 4 cycles -> count +1.
- Illegal jump 00 -> 11 held 20 cycles -> error=1, count unchanged. Assert err_clear -> error=0. Assert err_clear in the same cycle as a second illegal jump -> error=1.
- Preload by stepping to count=0x7_FFFF_FFFF (force or backdoor), then 1 forward step -> count=0x8_0000_0000. Also, count_clear in the same cycle as a step -> count=0, step=0.
- With QUAD_INDEX_RESET_EN: count=37, enc_i pulse while AB=00 -> count=0. Same pulse while AB=11 -> count=37. Without the macro, both cases give count=37.
